// File: rtl/gx4000_pkg.sv
// gx4000_pkg
// Shared types and constants for the GX4000 ASIC RAM arbiter.
//   req_id_t  : requester tag carried through the read-return pipeline
//   rr_t      : DMA/CPU round-robin pointer
//   ASIC_ADDR_W / ASIC_DATA_W : ASIC RAM geometry
//   RAM_DEFAULT_RD : read value returned while the Plus ASIC is locked
package gx4000_pkg;

   localparam int ASIC_ADDR_W = 14;
   localparam int ASIC_DATA_W = 8;

   localparam logic [ASIC_DATA_W-1:0] RAM_DEFAULT_RD = 8'hFF;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_SPR  = 2'd1,
      REQ_DMA  = 2'd2,
      REQ_CPU  = 2'd3
   } req_id_t;

   typedef enum logic {
      RR_DMA = 1'b0,
      RR_CPU = 1'b1
   } rr_t;

endpackage

// File: rtl/gx4000_arb_rdpipe.sv
// gx4000_arb_rdpipe
// Read-return pipeline: carries the tag of each granted read (and the
// plus_mode value at grant time) for two stages so it lines up with ram_q,
// then demuxes ram_q into registered per-requester rvalid/rdata.
// Ports:
//   clk_sys, reset_n         clock, async active-low reset (flushes tags)
//   plus_mode_i              plus_mode at the grant edge
//   rd_id_i [1:0]            req_id_t of the read granted this edge, or REQ_NONE
//   ram_q_i [7:0]            synchronous RAM output
//   {spr,dma,cpu}_rvalid_o   one-cycle read-data strobes
//   {spr,dma,cpu}_rdata_o    read data, held until the next strobe
module gx4000_arb_rdpipe
   import gx4000_pkg::*;
(
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   plus_mode_i,
   input  logic [1:0]             rd_id_i,
   input  logic [ASIC_DATA_W-1:0] ram_q_i,
   output logic                   spr_rvalid_o,
   output logic [ASIC_DATA_W-1:0] spr_rdata_o,
   output logic                   dma_rvalid_o,
   output logic [ASIC_DATA_W-1:0] dma_rdata_o,
   output logic                   cpu_rvalid_o,
   output logic [ASIC_DATA_W-1:0] cpu_rdata_o
);

   req_id_t                s1_id_q, s2_id_q;
   logic                   s1_plus_q, s2_plus_q;
   logic                   spr_rvalid_q, dma_rvalid_q, cpu_rvalid_q;
   logic [ASIC_DATA_W-1:0] spr_rdata_q, dma_rdata_q, cpu_rdata_q;
   logic [ASIC_DATA_W-1:0] rd_val;

   // stage 2 coincides with ram_q being valid for that read
   assign rd_val = s2_plus_q ? ram_q_i : RAM_DEFAULT_RD;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         s1_id_q      <= REQ_NONE;
         s2_id_q      <= REQ_NONE;
         s1_plus_q    <= 1'b0;
         s2_plus_q    <= 1'b0;
         spr_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         spr_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         s1_id_q      <= req_id_t'(rd_id_i);
         s1_plus_q    <= plus_mode_i;
         s2_id_q      <= s1_id_q;
         s2_plus_q    <= s1_plus_q;
         spr_rvalid_q <= (s2_id_q == REQ_SPR);
         dma_rvalid_q <= (s2_id_q == REQ_DMA);
         cpu_rvalid_q <= (s2_id_q == REQ_CPU);
         if (s2_id_q == REQ_SPR) spr_rdata_q <= rd_val;
         if (s2_id_q == REQ_DMA) dma_rdata_q <= rd_val;
         if (s2_id_q == REQ_CPU) cpu_rdata_q <= rd_val;
      end
   end

   assign spr_rvalid_o = spr_rvalid_q;
   assign dma_rvalid_o = dma_rvalid_q;
   assign cpu_rvalid_o = cpu_rvalid_q;
   assign spr_rdata_o  = spr_rdata_q;
   assign dma_rdata_o  = dma_rdata_q;
   assign cpu_rdata_o  = cpu_rdata_q;

endmodule

// File: rtl/gx4000_asic_ram_arbiter.sv
// gx4000_asic_ram_arbiter
// Single-port arbiter for the GX4000 ASIC RAM. One grant per cycle:
// guard-forced CPU, then sprite, then DMA/CPU by round-robin. RAM strobes
// and acks are registered; read data returns through gx4000_arb_rdpipe.
// Optional feature macro: GX4000_ARB_STARVE_GUARD_EN (CPU starvation guard).
// Ports:
//   clk_sys, reset_n                  clock, async active-low reset
//   plus_mode                         0 = writes suppressed, reads give 8'hFF
//   spr_req/spr_addr                  sprite read requests
//   dma_req/dma_we/dma_addr/dma_wdata DMA requests
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU requests
//   *_ack, *_rvalid, *_rdata          per-requester grant and read return
//   ram_addr/ram_rd/ram_wr/ram_din    RAM macro strobes; ram_q read data
//
// state  | meaning
// RR_DMA | DMA wins a DMA/CPU tie
// RR_CPU | CPU wins a DMA/CPU tie
module gx4000_asic_ram_arbiter
   import gx4000_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = 4
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   plus_mode,
   input  logic                   spr_req,
   input  logic [ASIC_ADDR_W-1:0] spr_addr,
   output logic                   spr_ack,
   output logic                   spr_rvalid,
   output logic [ASIC_DATA_W-1:0] spr_rdata,
   input  logic                   dma_req,
   input  logic                   dma_we,
   input  logic [ASIC_ADDR_W-1:0] dma_addr,
   input  logic [ASIC_DATA_W-1:0] dma_wdata,
   output logic                   dma_ack,
   output logic                   dma_rvalid,
   output logic [ASIC_DATA_W-1:0] dma_rdata,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ASIC_ADDR_W-1:0] cpu_addr,
   input  logic [ASIC_DATA_W-1:0] cpu_wdata,
   output logic                   cpu_ack,
   output logic                   cpu_rvalid,
   output logic [ASIC_DATA_W-1:0] cpu_rdata,
   output logic [ASIC_ADDR_W-1:0] ram_addr,
   output logic                   ram_rd,
   output logic                   ram_wr,
   output logic [ASIC_DATA_W-1:0] ram_din,
   input  logic [ASIC_DATA_W-1:0] ram_q
);

   if ((1 << WAIT_W) <= MAX_WAIT) begin : g_wait_w_check
      $error("WAIT_W too narrow to hold MAX_WAIT");
   end

   rr_t                    rr_q, rr_d;
   req_id_t                gnt;
   logic                   cpu_force;
   logic [ASIC_ADDR_W-1:0] sel_addr;
   logic                   sel_we;
   logic [ASIC_DATA_W-1:0] sel_wdata;
   logic [1:0]             rd_id;

   logic                   spr_ack_q, dma_ack_q, cpu_ack_q;
   logic                   ram_rd_q, ram_wr_q;
   logic [ASIC_ADDR_W-1:0] ram_addr_q;
   logic [ASIC_DATA_W-1:0] ram_din_q;

`ifdef GX4000_ARB_STARVE_GUARD_EN
   logic [WAIT_W-1:0] wait_q, wait_d;

   // saturates at MAX_WAIT so a long wait cannot wrap back to zero
   always_comb begin
      wait_d = wait_q;
      if (!cpu_req || gnt == REQ_CPU) begin
         wait_d = '0;
      end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) wait_q <= '0;
      else          wait_q <= wait_d;
   end

   assign cpu_force = cpu_req && (wait_q >= WAIT_W'(MAX_WAIT));
`else
   assign cpu_force = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rr_q <= RR_DMA;
      else          rr_q <= rr_d;
   end

   always_comb begin
      gnt  = REQ_NONE;
      rr_d = rr_q;
      if (cpu_force) begin
         gnt = REQ_CPU;
      end else if (spr_req) begin
         gnt = REQ_SPR;
      end else if (dma_req && cpu_req) begin
         gnt = (rr_q == RR_CPU) ? REQ_CPU : REQ_DMA;
      end else if (dma_req) begin
         gnt = REQ_DMA;
      end else if (cpu_req) begin
         gnt = REQ_CPU;
      end
      if (gnt == REQ_DMA) rr_d = RR_CPU;
      if (gnt == REQ_CPU) rr_d = RR_DMA;
   end

   always_comb begin
      sel_addr  = ram_addr_q;
      sel_we    = 1'b0;
      sel_wdata = ram_din_q;
      case (gnt)
         REQ_SPR: begin
            sel_addr = spr_addr;
         end
         REQ_DMA: begin
            sel_addr  = dma_addr;
            sel_we    = dma_we;
            sel_wdata = dma_wdata;
         end
         REQ_CPU: begin
            sel_addr  = cpu_addr;
            sel_we    = cpu_we;
            sel_wdata = cpu_wdata;
         end
         default: ;
      endcase
   end

   assign rd_id = (gnt != REQ_NONE && !sel_we) ? gnt : REQ_NONE;

   // acks and strobes share the grant edge so the requester sees ack with the strobe
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         spr_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         cpu_ack_q  <= 1'b0;
         ram_rd_q   <= 1'b0;
         ram_wr_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         spr_ack_q <= (gnt == REQ_SPR);
         dma_ack_q <= (gnt == REQ_DMA);
         cpu_ack_q <= (gnt == REQ_CPU);
         ram_rd_q  <= (gnt != REQ_NONE) && !sel_we;
         // locked ASIC: the grant still completes, only the RAM write is dropped
         ram_wr_q  <= (gnt != REQ_NONE) && sel_we && plus_mode;
         if (gnt != REQ_NONE)           ram_addr_q <= sel_addr;
         if (gnt != REQ_NONE && sel_we) ram_din_q  <= sel_wdata;
      end
   end

   assign spr_ack  = spr_ack_q;
   assign dma_ack  = dma_ack_q;
   assign cpu_ack  = cpu_ack_q;
   assign ram_rd   = ram_rd_q;
   assign ram_wr   = ram_wr_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

   gx4000_arb_rdpipe u_rdpipe (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .plus_mode_i  (plus_mode),
      .rd_id_i      (rd_id),
      .ram_q_i      (ram_q),
      .spr_rvalid_o (spr_rvalid),
      .spr_rdata_o  (spr_rdata),
      .dma_rvalid_o (dma_rvalid),
      .dma_rdata_o  (dma_rdata),
      .cpu_rvalid_o (cpu_rvalid),
      .cpu_rdata_o  (cpu_rdata)
   );

endmodule

// File: tb/tb_gx4000_asic_ram_arbiter.sv
module tb_gx4000_asic_ram_arbiter;

   localparam int MAX_WAIT = 8;
`ifdef GX4000_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        plus_mode;
   logic        spr_req, dma_req, dma_we, cpu_req, cpu_we;
   logic [13:0] spr_addr, dma_addr, cpu_addr;
   logic [7:0]  dma_wdata, cpu_wdata;
   logic        spr_ack, dma_ack, cpu_ack;
   logic        spr_rvalid, dma_rvalid, cpu_rvalid;
   logic [7:0]  spr_rdata, dma_rdata, cpu_rdata;
   logic [13:0] ram_addr;
   logic        ram_rd, ram_wr;
   logic [7:0]  ram_din;
   logic [7:0]  ram_q = 8'h00;

   always #5 clk_sys = ~clk_sys;

   gx4000_asic_ram_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
      .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack),
      .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_din(ram_din),
      .ram_q(ram_q)
   );

   // initial RAM contents as a function of address; writes override
   function automatic logic [7:0] pat(input int a);
      if (a == 'h200) return 8'h5A;
      return 8'((a * 7 + 3) & 255);
   endfunction

   // synchronous RAM macro
   logic [7:0] tb_mem  [0:16383];
   bit         tb_wrtn [0:16383];
   always @(posedge clk_sys) begin
      if (ram_rd) ram_q <= tb_wrtn[ram_addr] ? tb_mem[ram_addr] : pat(int'(ram_addr));
      if (ram_wr) begin
         tb_mem[ram_addr]  <= ram_din;
         tb_wrtn[ram_addr] <= 1'b1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int due; int id; logic [7:0] data; } rd_t;
   logic [7:0]  ref_mem [0:16383];
   int          m_rr, m_wait, m_cyc, last_win;
   rd_t         m_q[$];
   logic [2:0]  e_ack, e_rv;
   logic        e_rd, e_wr;
   logic [13:0] e_addr;
   logic [7:0]  e_din;
   logic [7:0]  e_rdata [3];

   task automatic model_reset();
      m_rr = 0; m_wait = 0; m_cyc = 0; last_win = 0;
      m_q.delete();
      e_ack = 0; e_rv = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_din = 0;
      for (int i = 0; i < 3; i++) e_rdata[i] = 8'h00;
   endtask

   // one clock edge: winner 0 none, 1 sprite, 2 DMA, 3 CPU
   task automatic model_edge();
      int win;
      logic [13:0] a;
      logic we;
      logic [7:0] wd;
      rd_t r;
      if (GUARD && cpu_req && m_wait >= MAX_WAIT) win = 3;
      else if (spr_req)            win = 1;
      else if (dma_req && cpu_req) win = (m_rr == 1) ? 3 : 2;
      else if (dma_req)            win = 2;
      else if (cpu_req)            win = 3;
      else                         win = 0;
      if (GUARD) begin
         if (!cpu_req || win == 3) m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      end
      if (win == 2) m_rr = 1;
      if (win == 3) m_rr = 0;
      e_rv = 0;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
         r = m_q.pop_front();
         e_rv[r.id-1] = 1'b1;
         e_rdata[r.id-1] = r.data;
      end
      e_ack = 0; e_rd = 0; e_wr = 0;
      if (win != 0) begin
         case (win)
            1: begin a = spr_addr; we = 1'b0;   wd = 8'h00;     end
            2: begin a = dma_addr; we = dma_we; wd = dma_wdata; end
            default: begin a = cpu_addr; we = cpu_we; wd = cpu_wdata; end
         endcase
         e_ack[win-1] = 1'b1;
         e_addr = a;
         if (we) begin
            e_din = wd;
            if (plus_mode) begin
               e_wr = 1'b1;
               ref_mem[a] = wd;
            end
         end else begin
            e_rd = 1'b1;
            m_q.push_back('{m_cyc + 2, win, plus_mode ? ref_mem[a] : 8'hFF});
         end
      end
      last_win = win;
      m_cyc++;
   endtask

   task automatic compare_all();
      chk("spr_ack", spr_ack, e_ack[0]);
      chk("dma_ack", dma_ack, e_ack[1]);
      chk("cpu_ack", cpu_ack, e_ack[2]);
      chk("ram_rd", ram_rd, e_rd);
      chk("ram_wr", ram_wr, e_wr);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_din", ram_din, e_din);
      chk("spr_rvalid", spr_rvalid, e_rv[0]);
      chk("dma_rvalid", dma_rvalid, e_rv[1]);
      chk("cpu_rvalid", cpu_rvalid, e_rv[2]);
      chk("spr_rdata", spr_rdata, e_rdata[0]);
      chk("dma_rdata", dma_rdata, e_rdata[1]);
      chk("cpu_rdata", cpu_rdata, e_rdata[2]);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk_sys);
      #1;
      compare_all();
   endtask

   task automatic idle();
      spr_req = 0; dma_req = 0; cpu_req = 0; dma_we = 0; cpu_we = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_spr_ack"}, spr_ack, 0);
      chk({tag, "_dma_ack"}, dma_ack, 0);
      chk({tag, "_cpu_ack"}, cpu_ack, 0);
      chk({tag, "_ram_rd"}, ram_rd, 0);
      chk({tag, "_ram_wr"}, ram_wr, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_din"}, ram_din, 0);
      chk({tag, "_spr_rvalid"}, spr_rvalid, 0);
      chk({tag, "_dma_rvalid"}, dma_rvalid, 0);
      chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
      chk({tag, "_spr_rdata"}, spr_rdata, 0);
      chk({tag, "_dma_rdata"}, dma_rdata, 0);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
   endtask

   task automatic do_reset();
      idle();
      plus_mode = 1;
      reset_n = 0;
      #1;
      chk_reset("rst");
      model_reset();
      @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1;
   endtask

   function automatic int winner_now();
      if (spr_ack) return 1;
      if (dma_ack) return 2;
      if (cpu_ack) return 3;
      return 0;
   endfunction

   typedef struct { bit spr; bit dma; bit cpu; bit dwe; bit cwe; int exp_win; } vec_t;
   vec_t tbl[10];

   initial begin
      int first, spr_after, acks, wr_seen, crv;

      for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i);
      spr_addr = 0; dma_addr = 0; cpu_addr = 0; dma_wdata = 0; cpu_wdata = 0;
      idle();
      plus_mode = 1;

      // arbitration vectors from reset (rr prefers DMA)
      tbl[0] = '{0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 0, 0, 1};
      tbl[2] = '{0, 1, 1, 0, 0, 2};
      tbl[3] = '{0, 1, 1, 1, 0, 3};
      tbl[4] = '{1, 1, 1, 0, 1, 1};
      tbl[5] = '{0, 0, 1, 0, 1, 3};
      tbl[6] = '{0, 1, 1, 1, 1, 2};
      tbl[7] = '{0, 1, 0, 0, 0, 2};
      tbl[8] = '{0, 1, 1, 0, 0, 3};
      tbl[9] = '{1, 0, 1, 0, 0, 1};

      do_reset();

      // single CPU read of a preset location
      cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0200;
      step();
      chk("A_cpu_ack", cpu_ack, 1);
      idle();
      step();
      chk("A_rvalid_early", cpu_rvalid, 0);
      step();
      chk("A_cpu_rvalid", cpu_rvalid, 1);
      chk("A_cpu_rdata", cpu_rdata, 8'h5A);
      step();

      do_reset();
      for (int i = 0; i < 10; i++) begin
         spr_req = tbl[i].spr; dma_req = tbl[i].dma; cpu_req = tbl[i].cpu;
         dma_we = tbl[i].dwe; cpu_we = tbl[i].cwe;
         spr_addr = 14'(14'h0040 + i); dma_addr = 14'(14'h0080 + i); cpu_addr = 14'(14'h00C0 + i);
         dma_wdata = 8'($urandom); cpu_wdata = 8'($urandom);
         step();
         chk("tbl_winner", winner_now(), tbl[i].exp_win);
      end
      idle();
      repeat (3) step();

      // all three together, sprite drops after 6 cycles
      do_reset();
      spr_req = 1; dma_req = 1; cpu_req = 1;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) spr_req = 0;
         step();
         chk("B_order", winner_now(), (i < 6) ? 1 : ((i % 2 == 0) ? 2 : 3));
      end
      idle();
      repeat (3) step();

      // sprite and CPU held continuously
      do_reset();
      spr_req = 1; cpu_req = 1; cpu_addr = 14'h0011;
      first = -1; spr_after = 0; acks = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (cpu_ack) acks++;
         if (first > 0 && i == first + 1) spr_after = spr_ack;
         if (cpu_ack && first < 0) first = i;
      end
`ifdef GX4000_ARB_STARVE_GUARD_EN
      chk("C_cpu_wait_cycles", first - 1, MAX_WAIT);
      chk("C_spr_resumes", spr_after, 1);
`else
      chk("C_cpu_starved", acks, 0);
`endif
      idle();
      repeat (3) step();

      // locked ASIC: write suppressed, read returns FF
      do_reset();
      plus_mode = 0; wr_seen = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 8'hAA;
      step();
      chk("D_wr_ack", cpu_ack, 1);
      wr_seen |= ram_wr;
      cpu_we = 0;
      step();
      chk("D_rd_ack", cpu_ack, 1);
      wr_seen |= ram_wr;
      idle();
      step(); wr_seen |= ram_wr;
      step(); wr_seen |= ram_wr;
      chk("D_cpu_rvalid", cpu_rvalid, 1);
      chk("D_cpu_rdata", cpu_rdata, 8'hFF);
      chk("D_ram_wr_never", wr_seen, 0);
      plus_mode = 1;
      cpu_req = 1; cpu_addr = 14'h0010;
      step();
      idle();
      step(); step();
      chk("D_unlocked_rdata", cpu_rdata, pat('h10));

      // DMA read then CPU write on the next cycle
      do_reset();
      dma_req = 1; dma_we = 0; dma_addr = 14'h0100;
      step();
      chk("E_dma_ack", dma_ack, 1);
      chk("E_ram_rd", ram_rd, 1);
      chk("E_ram_addr", ram_addr, 14'h0100);
      idle();
      cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0300; cpu_wdata = 8'h77;
      step();
      chk("E_ram_wr", ram_wr, 1);
      chk("E_ram_rd_off", ram_rd, 0);
      crv = cpu_rvalid;
      idle();
      step();
      chk("E_dma_rvalid", dma_rvalid, 1);
      chk("E_dma_rdata", dma_rdata, pat('h100));
      crv |= cpu_rvalid;
      step();
      chk("E_dma_rvalid_once", dma_rvalid, 0);
      crv |= cpu_rvalid;
      chk("E_no_cpu_rvalid", crv, 0);

      // reset during a sprite read
      do_reset();
      spr_req = 1; spr_addr = 14'h0044;
      step();
      chk("F_spr_ack", spr_ack, 1);
      idle();
      #2 reset_n = 0;
      #1 chk_reset("F");
      model_reset();
      @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("F_no_spr_rvalid", spr_rvalid, 0);
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         spr_req = ($urandom_range(0, 2) == 0);
         dma_req = $urandom_range(0, 1) != 0;
         cpu_req = $urandom_range(0, 1) != 0;
         dma_we = $urandom_range(0, 1) != 0;
         cpu_we = $urandom_range(0, 1) != 0;
         spr_addr = 14'($urandom_range(0, 31));
         dma_addr = 14'($urandom_range(0, 31));
         cpu_addr = 14'($urandom_range(0, 31));
         dma_wdata = 8'($urandom);
         cpu_wdata = 8'($urandom);
         plus_mode = ($urandom_range(0, 7) != 0);
         step();
      end
      idle();
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gx4000_asic_ram_arbiter.md
# gx4000_asic_ram_arbiter

Single-port arbiter for the GX4000 ASIC RAM (14-bit address, 8-bit data), sitting between the ASIC RAM macro and three requesters: sprite pattern fetch, sound/DMA engine, and the CPU register/pattern-download path. It grants one access per cycle with fixed sprite priority, round-robin between DMA and CPU, and an optional CPU starvation guard. It returns read data to the correct requester through a tagged read-return pipeline.

## Interface
- MAX_WAIT, 8: cycles a pending CPU request may wait before it pre-empts sprite priority (starvation guard only).
- WAIT_W, 4: width of the starvation counter; must satisfy 2^WAIT_W > MAX_WAIT.
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- plus_mode  in  1  Plus ASIC unlocked; 0 = RAM writes suppressed, reads return 8'hFF.
- spr_req  in  1  sprite read request; read only, no write path.
- spr_addr  in  14  sprite read address.
- spr_ack  out  1  sprite request granted this cycle.
- spr_rvalid  out  1  sprite read data valid.
- spr_rdata  out  8  sprite read data.
- dma_req, dma_we  in  1 each  DMA request and write enable.
- dma_addr  in  14;  dma_wdata  in  8.
- dma_ack, dma_rvalid  out  1 each;  dma_rdata  out  8.
- cpu_req, cpu_we  in  1 each;  cpu_addr  in  14;  cpu_wdata  in  8.
- cpu_ack, cpu_rvalid  out  1 each;  cpu_rdata  out  8.
- ram_addr  out  14;  ram_rd, ram_wr  out  1 each;  ram_din  out  8.
- ram_q  in  8  synchronous RAM output, valid one cycle after ram_rd.

## Operation
- Requesters hold req, we, addr and wdata stable until they see ack high at a clock edge. They may present a new request in the cycle after ack.
- Each cycle, at most one requester is granted. Priority:
  - Guard-forced CPU first (see Configuration).
  - Then sprite.
  - Then DMA/CPU, resolved by a round-robin pointer `rr`.
- `rr` rules:
  - `rr` = 0 prefers DMA; `rr` = 1 prefers CPU.
  - After a DMA or CPU grant, `rr` points at the other requester.
  - A sprite grant leaves `rr` unchanged.
- A grant drives ram_addr, ram_rd/ram_wr and ram_din as registered outputs. The requester's ack is asserted in the same cycle as the strobe.
- Reads: the requester ID enters the read-return pipeline. Two cycles after the RAM strobe, the matching rvalid pulses for one cycle and rdata holds ram_q, registered.
  - Each rdata output holds its last value until the next rvalid.
- plus_mode = 0:
  - Grants and acks proceed normally, so requesters never hang.
  - ram_wr is forced to 0.
  - Returned read data is 8'hFF.
- No request pending: ram_rd = ram_wr = 0. ram_addr and ram_din hold their previous values.

## Timing
- Reset values of all outputs: 0, except ram_addr = 14'h0000. `rr` resets to 0. The starvation counter resets to 0.
- Latency, request sampled at edge k:
  - Best case: ack and ram strobe high during cycle k+1 (after edge k).
  - rvalid high during cycle k+3.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when it is the only one requesting.
- Simultaneous requests from all three: sprite wins. DMA and CPU then alternate on successive free cycles.
- Pipeline overlap: a write may be granted while an earlier read is in flight; rvalid ordering is unaffected.
- Reset asserted mid-operation: the pipeline is flushed and no rvalid fires for in-flight reads. Requesters must reissue after reset.

## Configuration
- GX4000_ARB_STARVE_GUARD_EN defined:
  - The counter increments each cycle cpu_req is high and un-acked, and clears on cpu_ack or when cpu_req is low.
  - When the counter reaches MAX_WAIT, CPU is granted ahead of sprite on the next grant.
- GX4000_ARB_STARVE_GUARD_EN undefined: no counter. Sprite priority is absolute and the CPU can starve during continuous sprite fetch.

## Structure
- Package gx4000_pkg holds:
  - typedef enum req_id_t {REQ_NONE, REQ_SPR, REQ_DMA, REQ_CPU}.
  - ASIC_ADDR_W = 14 and ASIC_DATA_W = 8.
  - The default RAM read value 8'hFF.
- Sub-module gx4000_arb_rdpipe: two-stage shift of req_id_t plus a plus_mode flag. It demuxes ram_q into the three rvalid/rdata pairs.

## Test plan
- Only cpu_req, read, addr 14'h0200, RAM holds 8'h5A there → cpu_ack 1 cycle after sampling; cpu_rvalid two cycles later with cpu_rdata = 8'h5A.
- spr_req, dma_req and cpu_req held together for 6 cycles, guard off → grant order SPR×6, then DMA, CPU, DMA… once spr_req drops.
- Guard on, MAX_WAIT = 8, spr_req and cpu_req held continuously → cpu_ack occurs after exactly 8 cycles of waiting, then the sprite resumes.
- plus_mode = 0, cpu write 8'hAA to 14'h0010, then a read of 14'h0010 → ram_wr never asserts; cpu_ack pulses; cpu_rdata = 8'hFF.
- DMA read at 14'h0100 followed the next cycle by a CPU write → ram strobes on consecutive cycles; dma_rvalid fires only for the read, with the correct data.
- reset_n pulsed low one cycle after a sprite read grant → no spr_rvalid; all outputs return to 0 asynchronously.
